// File: rtl/ex_divider.sv
// ----------------------------------------------------------------------------
// ex_divider
//
// Iterative radix-2 restoring divider for the RV64M DIV/DIVU/REM/REMU
// instructions and their W variants. It sits in the EX stage and holds the
// pipeline through stall_req_o while a division is in flight, then presents
// the result for exactly one cycle (done_o) while the stall is released so
// EX/MEM captures it.
//
// Ports:
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   start_i      ID/EX holds a valid divide/remainder instruction
//   op_i         00 DIV, 01 DIVU, 10 REM, 11 REMU
//   word_i       W variant: operate on src[31:0], sign-extend the result
//   src1_i       dividend
//   src2_i       divisor
//   kill_i       abort the in-flight operation (trap or redirect)
//   stall_req_o  combinational stall request to the hazard controller
//   done_o       registered; result_o is valid this cycle
//   result_o     registered quotient or remainder
//
// Configuration macro:
//   DIV_WORD_FAST_EN  when defined, W ops iterate 32 times on 32-bit
//                     magnitudes instead of 64; results are identical,
//                     only latency changes.
// ----------------------------------------------------------------------------
module ex_divider (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic        word_i,
    input  logic [63:0] src1_i,
    input  logic [63:0] src2_i,
    input  logic        kill_i,
    output logic        stall_req_o,
    output logic        done_o,
    output logic [63:0] result_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0]  ITER_64   = 7'd64;
`ifdef DIV_WORD_FAST_EN
    localparam logic [6:0]  ITER_32   = 7'd32;
`endif
    localparam logic [63:0] MIN_64    = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MIN_32_SX = 64'hFFFF_FFFF_8000_0000;

    // Sequential state
    state_t      state_q, state_d;
    logic [6:0]  count_q;
    logic [63:0] rem_q;
    logic [63:0] quo_q;
    logic [63:0] dvs_q;
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic        rem_op_q;
    logic        word_q;
    logic        done_q;
    logic [63:0] result_q;

    // Operand preparation (only meaningful in the IDLE start cycle)
    logic        signed_op;
    logic        rem_op;
    logic [63:0] a_ext, b_ext;
    logic        a_neg, b_neg;
    logic [63:0] mag_a, mag_b;
    logic        div_zero;
    logic        overflow;
    logic        special;
    logic [63:0] special_res;
    logic [63:0] quo_load;
    logic [6:0]  n_iter;

    // One restoring step
    logic [64:0] shifted;
    logic [64:0] trial;
    logic        fits;
    logic [63:0] rem_step;
    logic [63:0] quo_step;

    // Apply signs to the unsigned quotient/remainder, select the requested
    // one, and sign-extend the low word for W ops.
    function automatic logic [63:0] finalize(
        input logic [63:0] quo,
        input logic [63:0] rem,
        input logic        neg_quo,
        input logic        neg_rem,
        input logic        is_rem,
        input logic        is_word
    );
        logic [63:0] val;
        if (is_rem) val = neg_rem ? (~rem + 64'd1) : rem;
        else        val = neg_quo ? (~quo + 64'd1) : quo;
        return is_word ? {{32{val[31]}}, val[31:0]} : val;
    endfunction

    assign signed_op = ~op_i[0];
    assign rem_op    = op_i[1];

    always_comb begin
        // NOTE: every signal written here gets a value on every path first,
        // otherwise synthesis infers a latch to hold the old value.
        a_ext    = src1_i;
        b_ext    = src2_i;
        quo_load = '0;
        n_iter   = ITER_64;

        if (word_i) begin
            a_ext = signed_op ? {{32{src1_i[31]}}, src1_i[31:0]} : {32'h0, src1_i[31:0]};
            b_ext = signed_op ? {{32{src2_i[31]}}, src2_i[31:0]} : {32'h0, src2_i[31:0]};
        end

        a_neg = signed_op & a_ext[63];
        b_neg = signed_op & b_ext[63];
        // Negating the most-negative value yields 2^63, which is the correct
        // unsigned magnitude.
        mag_a = a_neg ? (~a_ext + 64'd1) : a_ext;
        mag_b = b_neg ? (~b_ext + 64'd1) : b_ext;

        div_zero = (b_ext == 64'd0);
        overflow = signed_op
                 & (a_ext == (word_i ? MIN_32_SX : MIN_64))
                 & (b_ext == {64{1'b1}});
        special  = div_zero | overflow;

        // Divide-by-zero: quotient all ones, remainder the dividend.
        // Overflow: quotient is the dividend (most-negative), remainder 0.
        special_res = finalize(div_zero ? {64{1'b1}} : a_ext,
                               div_zero ? a_ext : 64'd0,
                               1'b0, 1'b0, rem_op, word_i);

`ifdef DIV_WORD_FAST_EN
        // W magnitudes fit in 32 bits; park them in the top half so the
        // first 32 shifts consume them.
        if (word_i) begin
            n_iter   = ITER_32;
            quo_load = {mag_a[31:0], 32'h0};
        end else begin
            quo_load = mag_a;
        end
`else
        quo_load = mag_a;
`endif
    end

    // Remainder stays below the divisor, so the shifted value fits in 65 bits
    // and bit 64 of the trial difference is a clean borrow flag.
    assign shifted  = {rem_q, quo_q[63]};
    assign trial    = shifted - {1'b0, dvs_q};
    assign fits     = ~trial[64];
    assign rem_step = fits ? trial[63:0] : shifted[63:0];
    assign quo_step = {quo_q[62:0], fits};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = special ? DONE : CALC;
            CALC:    if (count_q == 7'd1) state_d = DONE;
            DONE:    state_d = IDLE;  // start_i here is the instruction being released
            default: state_d = IDLE;
        endcase
        if (kill_i) state_d = IDLE;
    end

    assign stall_req_o = ~kill_i & (((state_q == IDLE) & start_i) | (state_q == CALC));
    assign done_o      = done_q;
    assign result_o    = result_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: datapath registers are reset alongside control so no
            // partial result can ever reach result_o after reset.
            state_q   <= IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_op_q  <= 1'b0;
            word_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == DONE);
            if (kill_i) begin
                count_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            dvs_q     <= mag_b;
                            rem_q     <= '0;
                            quo_q     <= quo_load;
                            neg_quo_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            rem_op_q  <= rem_op;
                            word_q    <= word_i;
                            count_q   <= special ? 7'd0 : n_iter;
                            if (special) result_q <= special_res;
                        end
                    end
                    CALC: begin
                        rem_q   <= rem_step;
                        quo_q   <= quo_step;
                        count_q <= count_q - 7'd1;
                        if (count_q == 7'd1)
                            result_q <= finalize(quo_step, rem_step, neg_quo_q,
                                                 neg_rem_q, rem_op_q, word_q);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_divider.sv
// ----------------------------------------------------------------------------
// tb_ex_divider
//
// Self-checking bench for ex_divider: a table of directed vectors with
// hand-computed results and stall latencies, followed by hand-written
// sequences for kill, kill+start collision and reset during CALC.
// ----------------------------------------------------------------------------
module tb_ex_divider;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    // Cycles with stall_req_o high before done_o appears.
    localparam int LAT_64 = 65;
`ifdef DIV_WORD_FAST_EN
    localparam int LAT_W  = 33;
`else
    localparam int LAT_W  = 65;
`endif
    localparam int LAT_SP = 1;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start_i;
    logic [1:0]  op_i;
    logic        word_i;
    logic [63:0] src1_i;
    logic [63:0] src2_i;
    logic        kill_i;
    logic        stall_req_o;
    logic        done_o;
    logic [63:0] result_o;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    ex_divider dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start_i    (start_i),
        .op_i       (op_i),
        .word_i     (word_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .kill_i     (kill_i),
        .stall_req_o(stall_req_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic add_vec(input string name, input logic [1:0] op, input logic word,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp, input int lat);
        vec_t v;
        v.name = name; v.op = op; v.word = word;
        v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Entered just after a rising edge; leaves just after the rising edge that
    // ends the DONE cycle, so consecutive calls issue back-to-back.
    // start_i is held through CALC and DONE as the pipeline would, while the
    // operand and op inputs are scrambled to prove they are sampled once.
    task automatic run_op(input vec_t v);
        int cyc;
        int stall_cnt;
        logic got_done;
        cyc = 0; stall_cnt = 0; got_done = 1'b0;
        start_i = 1'b1; op_i = v.op; word_i = v.word;
        src1_i = v.a;   src2_i = v.b; kill_i = 1'b0;
        while (cyc < 200) begin
            @(negedge clock);
            if (done_o) begin
                got_done = 1'b1;
                break;
            end
            if (stall_req_o) stall_cnt++;
            cyc++;
            @(posedge clock); #1;
            src1_i = ~src1_i; src2_i = ~src2_i; op_i = ~op_i; word_i = ~word_i;
        end
        check({v.name, " done seen"}, 64'(got_done), 64'd1);
        check({v.name, " cycles to done"}, 64'(cyc), 64'(v.lat));
        check({v.name, " stall cycles"}, 64'(stall_cnt), 64'(v.lat));
        check({v.name, " stall in DONE"}, 64'(stall_req_o), 64'd0);
        check({v.name, " result"}, result_o, v.exp);
        @(posedge clock); #1;
        start_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;

        reset_n = 1'b0; start_i = 1'b0; kill_i = 1'b0;
        op_i = 2'b00; word_i = 1'b0; src1_i = '0; src2_i = '0;

        add_vec("DIVU 100/7",       OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, LAT_64);
        add_vec("REMU 100/7",       OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2,  LAT_64);
        add_vec("DIV -7/2",         OP_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, LAT_64);
        add_vec("REM -7/2",         OP_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, LAT_64);
        add_vec("DIV 7/-2",         OP_DIV,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, LAT_64);
        add_vec("REM 7/-2",         OP_REM,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, LAT_64);
        add_vec("DIV -100/-7",      OP_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'd14, LAT_64);
        add_vec("REM -100/-7",      OP_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, LAT_64);
        add_vec("DIV max/16",       OP_DIV,  1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd16, 64'h07FF_FFFF_FFFF_FFFF, LAT_64);
        add_vec("REM max/16",       OP_REM,  1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd16, 64'd15, LAT_64);
        add_vec("DIVU ones/ones-1", OP_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, LAT_64);
        add_vec("REMU ones/ones-1", OP_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, LAT_64);
        add_vec("DIV 5/0",          OP_DIV,  1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, LAT_SP);
        add_vec("REM 5/0",          OP_REM,  1'b0, 64'd5, 64'd0, 64'd5, LAT_SP);
        add_vec("DIV min/-1",       OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, LAT_SP);
        add_vec("REM min/-1",       OP_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, LAT_SP);
        add_vec("DIVW min/-1",      OP_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, LAT_SP);
        add_vec("DIVUW ones/1",     OP_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, LAT_W);
        add_vec("REMW -7/2",        OP_REM,  1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF, LAT_W);
        add_vec("DIVUW 2^31/2",     OP_DIVU, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd2, 64'h0000_0000_4000_0000, LAT_W);
        add_vec("DIVUW 7/ones",     OP_DIVU, 1'b1, 64'd7, 64'h0000_0000_FFFF_FFFF, 64'd0, LAT_W);
        add_vec("REMUW x/0",        OP_REMU, 1'b1, 64'h1111_1111_8000_0005, 64'h2222_2222_0000_0000, 64'hFFFF_FFFF_8000_0005, LAT_SP);
        add_vec("DIVW x/0",         OP_DIV,  1'b1, 64'h0000_0000_0000_0009, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, LAT_SP);

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset stall_req_o", 64'(stall_req_o), 64'd0);
        check("reset done_o",      64'(done_o),      64'd0);
        check("reset result_o",    result_o,         64'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Table, issued back-to-back
        foreach (vecs[i]) run_op(vecs[i]);

        // Kill in CALC cycle 20
        start_i = 1'b1; op_i = OP_DIVU; word_i = 1'b0; src1_i = 64'd1000; src2_i = 64'd3;
        bad = 0;
        repeat (20) begin
            @(negedge clock);
            if (done_o || !stall_req_o) bad++;
            @(posedge clock); #1;
        end
        check("kill pre stall/done", 64'(bad), 64'd0);
        kill_i = 1'b1;
        #1;
        check("kill stall drop", 64'(stall_req_o), 64'd0);
        @(negedge clock);
        check("kill done_o", 64'(done_o), 64'd0);
        @(posedge clock); #1;
        kill_i = 1'b0;
        // Starting at once proves the block is back in IDLE with no leftover done
        begin
            vec_t v;
            v.name = "DIVU 9/3 after kill"; v.op = OP_DIVU; v.word = 1'b0;
            v.a = 64'd9; v.b = 64'd3; v.exp = 64'd3; v.lat = LAT_64;
            run_op(v);
        end

        // kill_i and start_i together in IDLE: nothing starts
        start_i = 1'b1; kill_i = 1'b1; op_i = OP_DIVU; src1_i = 64'd50; src2_i = 64'd5;
        #1;
        check("kill+start stall", 64'(stall_req_o), 64'd0);
        @(posedge clock); #1;
        start_i = 1'b0; kill_i = 1'b0;
        bad = 0;
        repeat (70) begin
            @(negedge clock);
            if (done_o || stall_req_o) bad++;
        end
        check("kill+start no activity", 64'(bad), 64'd0);
        @(posedge clock); #1;

        // Reset mid-CALC; result_o still holds 3 from the previous divide
        start_i = 1'b1; op_i = OP_DIVU; word_i = 1'b0; src1_i = 64'd1000; src2_i = 64'd7;
        repeat (10) begin @(posedge clock); #1; end
        check("pre-reset stall", 64'(stall_req_o), 64'd1);
        reset_n = 1'b0; start_i = 1'b0;
        #1;
        check("mid-reset done_o",      64'(done_o),      64'd0);
        check("mid-reset result_o",    result_o,         64'd0);
        check("mid-reset stall_req_o", 64'(stall_req_o), 64'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        bad = 0;
        repeat (70) begin
            @(negedge clock);
            if (done_o || stall_req_o || (result_o != 64'd0)) bad++;
        end
        check("post-reset quiet", 64'(bad), 64'd0);
        @(posedge clock); #1;
        begin
            vec_t v;
            v.name = "REMU 10/4 after reset"; v.op = OP_REMU; v.word = 1'b0;
            v.a = 64'd10; v.b = 64'd4; v.exp = 64'd2; v.lat = LAT_64;
            run_op(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_divider.md
# ex_divider

Iterative radix-2 restoring divider for the RV64M DIV/DIVU/REM/REMU and W-variant instructions, living in the EX stage. It requests a pipeline stall through `stall_req_o`, which drives the hazard controller's `ex_div_i` input, for the whole time a division is in flight. It then presents the result for exactly one cycle, while the stall is released, so EX/MEM captures it.

## Interface
- No parameters.
- `clock` input 1: single rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `start_i` input 1: ID/EX holds a valid divide/remainder instruction.
- `op_i` input 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `word_i` input 1: W variant; operates on `src[31:0]`.
- `src1_i` input 64: dividend.
- `src2_i` input 64: divisor.
- `kill_i` input 1: abort the in-flight operation (trap or redirect).
- `stall_req_o` output 1: combinational; to controller `ex_div_i`.
- `done_o` output 1: registered; `result_o` is valid this cycle.
- `result_o` output 64: registered quotient or remainder.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, `start_i`=1, `kill_i`=0:
  - Latch operands and op.
  - Normal case: go to CALC and load the iteration counter with N.
  - Special case: go to DONE directly.
- CALC:
  - One quotient bit per cycle.
  - Shift the {remainder, quotient} pair left 1; trial-subtract |divisor|; restore if negative.
  - Decrement the counter; when it reaches 1, go to DONE.
- DONE:
  - `done_o`=1 and `result_o` valid.
  - `start_i` is ignored; it is the same instruction being released.
  - Always return to IDLE next cycle.
- `kill_i`=1 in any state: next state IDLE and `done_o`=0. `stall_req_o` is forced to 0 in that same cycle.
- `stall_req_o` = !`kill_i` && ((IDLE && `start_i`) || CALC).
- Operand preparation:
  - Signed ops (DIV, REM) divide absolute values.
  - Quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - W ops: operands are `src[31:0]`, sign-extended (DIV/REM) or zero-extended (DIVU/REMU) to 64 bits. The final result is the low 32 bits sign-extended to 64, for all four W ops.
- Special cases (no iteration):
  - Divisor zero: quotient is all ones; remainder is the dividend (W: `sext(src1[31:0])`).
  - Signed overflow (most-negative / -1, at 64- or 32-bit width per `word_i`): quotient is the most-negative value (W: `0xFFFFFFFF80000000`); remainder is 0.
- N = 64, except W ops under `DIV_WORD_FAST_EN` (see Configuration).

## Timing
- Reset, asynchronous: state IDLE, counter 0, `result_o`=0, `done_o`=0.
- `stall_req_o` is 0 in reset, since IDLE with no start is combinational 0.
- Normal op, `start_i` first seen in cycle T:
  - `stall_req_o` high in cycles T through T+N.
  - DONE in cycle T+N+1: `stall_req_o`=0, `done_o`=1.
  - IDLE at T+N+2.
  - Total EX occupancy is N+2 cycles.
- Special case: stall only in cycle T; DONE at T+1.
- Back-to-back divides: the second instruction enters EX while the block is in IDLE at T+N+2 and starts with no bubble beyond that cycle.
- Reset asserted mid-CALC: immediate return to IDLE and outputs cleared. Partial results are discarded and never appear on `result_o`.
- `kill_i` and `start_i` in the same IDLE cycle: `kill_i` wins and no operation starts.
- Operand inputs are sampled only in the IDLE start cycle. Changes during CALC are ignored.

## Configuration
- `DIV_WORD_FAST_EN` defined:
  - W ops iterate N=32, on 32-bit magnitudes, so DONE arrives at T+33.
  - 64-bit ops are unchanged.
- `DIV_WORD_FAST_EN` undefined: all ops use N=64. W results are bit-identical to the fast mode; only latency differs.

## Test plan
- DIVU: 100 / 7 -> `stall_req_o` high 65 cycles, then `done_o`=1 with `result_o`=14. Repeat as REMU -> `result_o`=2.
- DIV: -7 / 2 -> `result_o`=`0xFFFFFFFFFFFFFFFD` (-3). REM: -7 / 2 -> `result_o`=`0xFFFFFFFFFFFFFFFF` (-1).
- DIV x / 0 with x=5 -> stall 1 cycle, then `result_o`=`0xFFFFFFFFFFFFFFFF`. REM 5 / 0 -> 5.
- DIVW: `0x80000000` / `0xFFFFFFFF` -> `result_o`=`0xFFFFFFFF80000000`, stall 1 cycle. DIVUW: `0xFFFFFFFF` / 1 -> `0xFFFFFFFFFFFFFFFF`. DONE at T+33 with the macro defined, T+65 without.
- `kill_i` pulsed in CALC cycle 20 -> `stall_req_o` drops that cycle, IDLE next cycle, `done_o` never asserts. A following DIVU 9 / 3 returns 3.
- `reset_n` dropped mid-CALC -> outputs 0 immediately. After release, a fresh REMU 10 / 4 returns 2.
